// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle core sequencer.
// State codes and the default memory-wait limit.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6,
    S_FAULT     = 3'd7
  } state_e;

  localparam int unsigned WAIT_TIMEOUT_DEF = 16;

endpackage

// File: rtl/mem_wait_watchdog.sv
// Counts memory request cycles without ready; flags timeout in req cycle LIMIT.
// Ports: clk, rst_n, clr (entry to a req state), req, ready -> timeout.
module mem_wait_watchdog #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic req,
  input  logic ready,
  output logic timeout
);

  localparam int unsigned W = $clog2(LIMIT);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // During req cycle k the counter holds k-1, so cycle LIMIT sees LAST.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (req && !ready && cnt_q != LAST) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout = req && !ready && (cnt_q == LAST);

endmodule

// File: rtl/cpu_stage_sequencer.sv
// Multi-cycle control FSM: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK enables,
// memory handshakes, watchdog fault, halt and retired-instruction counter.
module cpu_stage_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned WAIT_TIMEOUT = WAIT_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic             RegWrite,
  input  logic             Branch,
  input  logic             BranchTaken,
  input  logic             illegal,
  input  logic             halt_insn,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_we,
  output logic             ex_latch_we,
  output logic             rf_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             busy,
  output logic             halted,
  output logic             fault,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  state_e state_q;
  state_e state_d;
  logic [CNT_W-1:0] instret_q;
  logic [CNT_W-1:0] instret_d;
  logic retire;

  logic wd_clr;
  logic wd_req;
  logic wd_ready;
  logic wd_timeout;

  assign wd_req   = (state_q == S_FETCH) || (state_q == S_MEMORY);
  assign wd_ready = (state_q == S_FETCH) ? imem_ready : dmem_ready;
  assign wd_clr   = (state_d != state_q) &&
                    ((state_d == S_FETCH) || (state_d == S_MEMORY));

  mem_wait_watchdog #(
    .LIMIT(WAIT_TIMEOUT)
  ) u_wd (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wd_clr),
    .req     (wd_req),
    .ready   (wd_ready),
    .timeout (wd_timeout)
  );

  always_comb begin
    state_d     = state_q;
    ir_we       = 1'b0;
    ex_latch_we = 1'b0;
    rf_we       = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = 1'b0;
    retire      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (wd_timeout) begin
          state_d = S_FAULT;
        end
      end
      S_DECODE: begin
        unique case (1'b1)
          illegal:   state_d = S_FAULT;
          halt_insn: state_d = S_HALT;
          default:   state_d = S_EXECUTE;
        endcase
      end
      S_EXECUTE: begin
        ex_latch_we = 1'b1;
        if (MemRead && MemWrite) begin
          state_d = S_FAULT;
        end else if (MemRead || MemWrite) begin
          state_d = S_MEMORY;
        end else if (RegWrite) begin
          state_d = S_WRITEBACK;
        end else begin
          pc_we   = 1'b1;
          pc_sel  = Branch && BranchTaken;
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEMORY: begin
        if (dmem_ready) begin
          if (MemWrite) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else if (wd_timeout) begin
          state_d = S_FAULT;
        end
      end
      S_WRITEBACK: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: begin
        if (start) state_d = S_FETCH;
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase
  end

  always_comb begin
    instret_d = instret_q;
    if (retire) instret_d = instret_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  assign imem_req = (state_q == S_FETCH);
  assign dmem_req = (state_q == S_MEMORY);
  assign dmem_we  = (state_q == S_MEMORY) && MemWrite;
  assign halted   = (state_q == S_HALT);
  assign fault    = (state_q == S_FAULT);
  assign busy     = (state_q != S_IDLE) && (state_q != S_HALT) &&
                    (state_q != S_FAULT);
  assign state    = state_q;
  assign instret  = instret_q;

endmodule

// File: tb/tb_cpu_stage_sequencer.sv
// Directed bench for cpu_stage_sequencer.
// Per-cycle output vectors compared at #1 after each falling edge.
module tb_cpu_stage_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic MemRead = 1'b0;
  logic MemWrite = 1'b0;
  logic RegWrite = 1'b0;
  logic Branch = 1'b0;
  logic BranchTaken = 1'b0;
  logic illegal = 1'b0;
  logic halt_insn = 1'b0;
  logic imem_ready = 1'b0;
  logic dmem_ready = 1'b0;
  logic imem_req, dmem_req, dmem_we, ir_we, ex_latch_we;
  logic rf_we, pc_we, pc_sel, busy, halted, fault;
  logic [2:0] state;
  logic [31:0] instret;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cpu_stage_sequencer #(
    .CNT_W(32),
    .WAIT_TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .Branch(Branch),
    .BranchTaken(BranchTaken), .illegal(illegal),
    .halt_insn(halt_insn), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .imem_req(imem_req),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .ir_we(ir_we), .ex_latch_we(ex_latch_we),
    .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .busy(busy), .halted(halted), .fault(fault),
    .state(state), .instret(instret)
  );

  // {state, imem_req, dmem_req, dmem_we, ir_we, ex_latch_we,
  //  rf_we, pc_we, pc_sel, busy, halted, fault}
  logic [13:0] obs;
  assign obs = {state, imem_req, dmem_req, dmem_we, ir_we,
                ex_latch_we, rf_we, pc_we, pc_sel, busy,
                halted, fault};

  localparam logic [13:0] V_IDLE    = {3'd0, 11'b00000000000};
  localparam logic [13:0] V_FETCH_W = {3'd1, 11'b10000000100};
  localparam logic [13:0] V_FETCH_R = {3'd1, 11'b10010000100};
  localparam logic [13:0] V_DEC     = {3'd2, 11'b00000000100};
  localparam logic [13:0] V_EX      = {3'd3, 11'b00001000100};
  localparam logic [13:0] V_EX_BT   = {3'd3, 11'b00001011100};
  localparam logic [13:0] V_EX_BN   = {3'd3, 11'b00001010100};
  localparam logic [13:0] V_MEM_LD  = {3'd4, 11'b01000000100};
  localparam logic [13:0] V_MEM_ST  = {3'd4, 11'b01100010100};
  localparam logic [13:0] V_WB      = {3'd5, 11'b00000110100};
  localparam logic [13:0] V_HALT    = {3'd6, 11'b00000000010};
  localparam logic [13:0] V_FAULT   = {3'd7, 11'b00000000001};

  task automatic do_reset();
    rst_n = 1'b0;
    start = 0; MemRead = 0; MemWrite = 0; RegWrite = 0;
    Branch = 0; BranchTaken = 0; illegal = 0; halt_insn = 0;
    imem_ready = 0; dmem_ready = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    imem_ready = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++;
    if (obs !== V_IDLE)
      $display("FAIL reset_outs: got %b want %b", obs, V_IDLE);
    if (obs !== V_IDLE) n_bad++;
    n_cmp++;
    if (instret !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_instret: got %0d want 0", instret);
    end
    do_reset();
  endtask

  task automatic test_add();
    logic [13:0] ev [6];
    ev = '{V_IDLE, V_FETCH_R, V_DEC, V_EX, V_WB, V_FETCH_W};
    do_reset();
    start = 1; RegWrite = 1;
    for (int i = 0; i < 6; i++) begin
      imem_ready = (i != 5);
      #1;
      n_cmp++;
      if (obs !== ev[i]) begin
        n_bad++;
        $display("FAIL add c%0d: got %b want %b", i, obs, ev[i]);
      end
      if (i < 5) @(negedge clk);
    end
    n_cmp++;
    if (instret !== 32'd1) begin
      n_bad++;
      $display("FAIL add_instret: got %0d want 1", instret);
    end
  endtask

  task automatic test_reset_midfetch();
    @(negedge clk);
    #1;
    n_cmp++;
    if (obs !== V_FETCH_W) begin
      n_bad++;
      $display("FAIL midf_pre: got %b want %b", obs, V_FETCH_W);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== V_IDLE || instret !== 32'd0) begin
      n_bad++;
      $display("FAIL midf_rst: got %b/%0d want %b/0",
               obs, instret, V_IDLE);
    end
    do_reset();
  endtask

  task automatic test_load();
    logic [13:0] ev [10];
    ev = '{V_IDLE, V_FETCH_R, V_DEC, V_EX, V_MEM_LD,
           V_MEM_LD, V_MEM_LD, V_MEM_LD, V_WB, V_FETCH_R};
    do_reset();
    start = 1; imem_ready = 1; MemRead = 1; RegWrite = 1;
    for (int i = 0; i < 10; i++) begin
      dmem_ready = (i == 7);
      #1;
      n_cmp++;
      if (obs !== ev[i]) begin
        n_bad++;
        $display("FAIL load c%0d: got %b want %b", i, obs, ev[i]);
      end
      if (i < 9) @(negedge clk);
    end
    n_cmp++;
    if (instret !== 32'd1) begin
      n_bad++;
      $display("FAIL load_instret: got %0d want 1", instret);
    end
  endtask

  task automatic test_store();
    logic [13:0] ev [6];
    ev = '{V_IDLE, V_FETCH_R, V_DEC, V_EX, V_MEM_ST, V_FETCH_R};
    do_reset();
    start = 1; imem_ready = 1; MemWrite = 1; dmem_ready = 1;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_cmp++;
      if (obs !== ev[i]) begin
        n_bad++;
        $display("FAIL store c%0d: got %b want %b", i, obs, ev[i]);
      end
      if (i < 5) @(negedge clk);
    end
    n_cmp++;
    if (instret !== 32'd1) begin
      n_bad++;
      $display("FAIL store_instret: got %0d want 1", instret);
    end
  endtask

  task automatic test_back_to_back_branch();
    logic [13:0] ev [8];
    ev = '{V_IDLE, V_FETCH_R, V_DEC, V_EX_BT,
           V_FETCH_R, V_DEC, V_EX_BN, V_FETCH_R};
    do_reset();
    start = 1; imem_ready = 1; Branch = 1;
    for (int i = 0; i < 8; i++) begin
      BranchTaken = (i < 5);
      #1;
      n_cmp++;
      if (obs !== ev[i]) begin
        n_bad++;
        $display("FAIL branch c%0d: got %b want %b", i, obs, ev[i]);
      end
      if (i < 7) @(negedge clk);
    end
    n_cmp++;
    if (instret !== 32'd2) begin
      n_bad++;
      $display("FAIL branch_instret: got %0d want 2", instret);
    end
  endtask

  task automatic test_halt_illegal();
    logic [13:0] ev [10];
    ev = '{V_IDLE, V_FETCH_R, V_DEC, V_HALT, V_HALT,
           V_HALT, V_FETCH_R, V_DEC, V_FAULT, V_FAULT};
    do_reset();
    imem_ready = 1;
    for (int i = 0; i < 10; i++) begin
      start = (i == 0) || (i >= 5);
      halt_insn = (i < 6);
      illegal = (i >= 6);
      #1;
      n_cmp++;
      if (obs !== ev[i]) begin
        n_bad++;
        $display("FAIL halt c%0d: got %b want %b", i, obs, ev[i]);
      end
      if (i < 9) @(negedge clk);
    end
    n_cmp++;
    if (instret !== 32'd0) begin
      n_bad++;
      $display("FAIL halt_instret: got %0d want 0", instret);
    end
  endtask

  task automatic test_memrw_fault();
    logic [13:0] ev [6];
    ev = '{V_IDLE, V_FETCH_R, V_DEC, V_EX, V_FAULT, V_FAULT};
    do_reset();
    start = 1; imem_ready = 1; MemRead = 1; MemWrite = 1;
    dmem_ready = 1;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_cmp++;
      if (obs !== ev[i]) begin
        n_bad++;
        $display("FAIL memrw c%0d: got %b want %b", i, obs, ev[i]);
      end
      if (i < 5) @(negedge clk);
    end
  endtask

  task automatic test_imem_timeout();
    logic [13:0] e;
    do_reset();
    start = 1;
    for (int i = 0; i < 20; i++) begin
      imem_ready = (i >= 17);
      e = (i == 0) ? V_IDLE : (i <= 16) ? V_FETCH_W : V_FAULT;
      #1;
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL itmo c%0d: got %b want %b", i, obs, e);
      end
      if (i < 19) @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== V_IDLE) begin
      n_bad++;
      $display("FAIL itmo_clr: got %b want %b", obs, V_IDLE);
    end
    do_reset();
  endtask

  task automatic test_timeout_edge();
    logic [13:0] e;
    do_reset();
    start = 1;
    for (int i = 0; i < 18; i++) begin
      imem_ready = (i == 16);
      e = (i == 0) ? V_IDLE : (i <= 15) ? V_FETCH_W :
          (i == 16) ? V_FETCH_R : V_DEC;
      #1;
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL tedge c%0d: got %b want %b", i, obs, e);
      end
      if (i < 17) @(negedge clk);
    end
  endtask

  task automatic test_dmem_timeout();
    logic [13:0] e;
    do_reset();
    start = 1; imem_ready = 1; MemRead = 1; RegWrite = 1;
    for (int i = 0; i < 22; i++) begin
      e = (i == 0) ? V_IDLE : (i == 1) ? V_FETCH_R :
          (i == 2) ? V_DEC : (i == 3) ? V_EX :
          (i <= 19) ? V_MEM_LD : V_FAULT;
      #1;
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL dtmo c%0d: got %b want %b", i, obs, e);
      end
      if (i < 21) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_reset_midfetch();
    test_load();
    test_store();
    test_back_to_back_branch();
    test_halt_illegal();
    test_memrw_fault();
    test_imem_timeout();
    test_timeout_edge();
    test_dmem_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
